// File: rtl/data_mem_if.sv
// Per-channel read/write valid/ready bundle between the GPU data-memory controller (master)
// and the data memory responder (slave).
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 8
`endif

interface data_mem_if #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned DATA_WIDTH    = `DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = `DATA_MEMORY_ADDRESS_WIDTH
);
    logic [NUM_CHANNELS-1:0]  read_valid;
    logic [ADDRESS_WIDTH-1:0] read_address  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  read_ready;
    logic [DATA_WIDTH-1:0]    read_data     [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  write_valid;
    logic [ADDRESS_WIDTH-1:0] write_address [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    write_data    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  write_ready;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        input  read_ready, read_data, write_ready
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        output read_ready, read_data, write_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-channel data memory answering the GPU data-memory channel protocol; each channel has its
// own latency FSM over one shared array. Define DATA_MEM_STATS_EN to add completion counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef DATA_MEMORY_ADDRESS_WIDTH
`define DATA_MEMORY_ADDRESS_WIDTH 8
`endif

module data_mem_responder #(
    parameter int unsigned NUM_CHANNELS  = 4,
    parameter int unsigned DATA_WIDTH    = `DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = `DATA_MEMORY_ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 2 ** ADDRESS_WIDTH,
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_LATENCY = 2
) (
    input  logic       clk,
    input  logic       reset,
`ifdef DATA_MEM_STATS_EN
    output logic [31:0] stat_read_count,
    output logic [31:0] stat_write_count,
`endif
    data_mem_if.slave  mem
);

    localparam int unsigned MaxLat = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY
                                                                    : WRITE_LATENCY;
    localparam int unsigned CntW   = $clog2(MaxLat) + 1;
    localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReadWait,
        StWriteWait,
        StRespondRead,
        StRespondWrite
    } state_e;

    logic [DATA_WIDTH-1:0]    storage [DEPTH];

    state_e                   state_q [NUM_CHANNELS];
    state_e                   state_d [NUM_CHANNELS];
    logic [CntW-1:0]          cnt_q   [NUM_CHANNELS];
    logic [CntW-1:0]          cnt_d   [NUM_CHANNELS];
    logic [ADDRESS_WIDTH-1:0] addr_q  [NUM_CHANNELS];
    logic [ADDRESS_WIDTH-1:0] addr_d  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    wdata_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    wdata_d [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    rdata_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]    rdata_d [NUM_CHANNELS];

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            addr_d[c]  = addr_q[c];
            wdata_d[c] = wdata_q[c];
            rdata_d[c] = rdata_q[c];
            case (state_q[c])
                StIdle: begin
                    // Read wins when both valids are up; the write waits for a later idle edge.
                    if (mem.read_valid[c]) begin
                        state_d[c] = StReadWait;
                        addr_d[c]  = mem.read_address[c];
                        cnt_d[c]   = CntW'(READ_LATENCY - 1);
                    end else if (mem.write_valid[c]) begin
                        state_d[c] = StWriteWait;
                        addr_d[c]  = mem.write_address[c];
                        wdata_d[c] = mem.write_data[c];
                        cnt_d[c]   = CntW'(WRITE_LATENCY - 1);
                    end
                end
                StReadWait: begin
                    if (cnt_q[c] == '0) begin
                        state_d[c] = StRespondRead;
                        rdata_d[c] = in_range(addr_q[c]) ? storage[addr_q[c][IdxW-1:0]] : '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] - 1'b1;
                    end
                end
                StWriteWait: begin
                    if (cnt_q[c] == '0) begin
                        state_d[c] = StRespondWrite;
                    end else begin
                        cnt_d[c] = cnt_q[c] - 1'b1;
                    end
                end
                StRespondRead: begin
                    if (!mem.read_valid[c]) state_d[c] = StIdle;
                end
                StRespondWrite: begin
                    if (!mem.write_valid[c]) state_d[c] = StIdle;
                end
                default: state_d[c] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= StIdle;
                cnt_q[c]   <= '0;
                addr_q[c]  <= '0;
                wdata_q[c] <= '0;
                rdata_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
                addr_q[c]  <= addr_d[c];
                wdata_q[c] <= wdata_d[c];
                rdata_q[c] <= rdata_d[c];
            end
        end
    end

    // Contents survive reset. Walking channels high-to-low lets the lowest index land last.
    always_ff @(posedge clk) begin
        for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
            if (state_q[c] == StWriteWait && cnt_q[c] == '0 && in_range(addr_q[c])) begin
                storage[addr_q[c][IdxW-1:0]] <= wdata_q[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem.read_ready[c]  = (state_q[c] == StRespondRead);
            mem.write_ready[c] = (state_q[c] == StRespondWrite);
            mem.read_data[c]   = rdata_q[c];
        end
    end

`ifdef DATA_MEM_STATS_EN
    logic [31:0] rd_done;
    logic [31:0] wr_done;
    logic [31:0] stat_read_q;
    logic [31:0] stat_write_q;

    always_comb begin
        rd_done = '0;
        wr_done = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_done = rd_done + 32'(state_q[c] == StRespondRead && !mem.read_valid[c]);
            wr_done = wr_done + 32'(state_q[c] == StRespondWrite && !mem.write_valid[c]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_read_q  <= '0;
            stat_write_q <= '0;
        end else begin
            stat_read_q  <= stat_read_q + rd_done;
            stat_write_q <= stat_write_q + wr_done;
        end
    end

    assign stat_read_count  = stat_read_q;
    assign stat_write_count = stat_write_q;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (4 channels, 16-bit data, 8-bit address,
// latency 2 both ways).
module tb_data_mem_responder;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fails;

`ifdef DATA_MEM_STATS_EN
    logic [31:0] stat_read_count;
    logic [31:0] stat_write_count;
`endif

    data_mem_if #(.NUM_CHANNELS(4), .DATA_WIDTH(16), .ADDRESS_WIDTH(8)) bus ();

    data_mem_responder #(
        .NUM_CHANNELS (4),
        .DATA_WIDTH   (16),
        .ADDRESS_WIDTH(8),
        .DEPTH        (256),
        .READ_LATENCY (2),
        .WRITE_LATENCY(2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
`ifdef DATA_MEM_STATS_EN
        .stat_read_count (stat_read_count),
        .stat_write_count(stat_write_count),
`endif
        .mem             (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bounded wait for read_ready, check data, then drop valid and check the ack falls.
    task automatic rd(input int ch, input logic [7:0] a, input logic [15:0] exp, input string tag);
        int n;
        bus.read_valid[ch]   = 1'b1;
        bus.read_address[ch] = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.read_ready[ch] && n < 20);
        check_eq({tag, "_ready"}, 32'(bus.read_ready[ch]), 32'd1);
        check_eq({tag, "_data"}, 32'(bus.read_data[ch]), 32'(exp));
        bus.read_valid[ch] = 1'b0;
        @(negedge clk);
        check_eq({tag, "_drop"}, 32'(bus.read_ready[ch]), 32'd0);
    endtask

    task automatic wr(input int ch, input logic [7:0] a, input logic [15:0] d, input string tag);
        int n;
        bus.write_valid[ch]   = 1'b1;
        bus.write_address[ch] = a;
        bus.write_data[ch]    = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.write_ready[ch] && n < 20);
        check_eq({tag, "_ready"}, 32'(bus.write_ready[ch]), 32'd1);
        bus.write_valid[ch] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        bus.read_valid  = '0;
        bus.write_valid = '0;
        for (int c = 0; c < 4; c++) begin
            bus.read_address[c]  = '0;
            bus.write_address[c] = '0;
            bus.write_data[c]    = '0;
        end
        repeat (2) @(negedge clk);
        check_eq("rst_read_ready", 32'(bus.read_ready), 32'd0);
        check_eq("rst_write_ready", 32'(bus.write_ready), 32'd0);
        check_eq("rst_read_data0", 32'(bus.read_data[0]), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Write then read on channel 0 with exact latency and hold/drop timing.
        bus.write_valid[0]   = 1'b1;
        bus.write_address[0] = 8'h05;
        bus.write_data[0]    = 16'h1234;
        @(negedge clk);
        check_eq("wr_lat_cap", 32'(bus.write_ready[0]), 32'd0);
        @(negedge clk);
        check_eq("wr_lat_early", 32'(bus.write_ready[0]), 32'd0);
        @(negedge clk);
        check_eq("wr_lat2", 32'(bus.write_ready[0]), 32'd1);
        @(negedge clk);
        check_eq("wr_hold", 32'(bus.write_ready[0]), 32'd1);
        bus.write_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("wr_drop", 32'(bus.write_ready[0]), 32'd0);

        bus.read_valid[0]   = 1'b1;
        bus.read_address[0] = 8'h05;
        @(negedge clk);
        @(negedge clk);
        check_eq("rd_lat_early", 32'(bus.read_ready[0]), 32'd0);
        @(negedge clk);
        check_eq("rd_lat2", 32'(bus.read_ready[0]), 32'd1);
        check_eq("rd_data", 32'(bus.read_data[0]), 32'h1234);
        @(negedge clk);
        check_eq("rd_hold_data", 32'(bus.read_data[0]), 32'h1234);
        bus.read_valid[0] = 1'b0;
        @(negedge clk);
        check_eq("rd_drop", 32'(bus.read_ready[0]), 32'd0);

        // Four channels read distinct addresses on the same edge.
        wr(0, 8'h01, 16'h0011, "pre1");
        wr(1, 8'h02, 16'h0022, "pre2");
        wr(2, 8'h03, 16'h0033, "pre3");
        wr(3, 8'h04, 16'h0044, "pre4");
        for (int c = 0; c < 4; c++) begin
            bus.read_address[c] = 8'(c + 1);
        end
        bus.read_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        check_eq("par_early", 32'(bus.read_ready), 32'd0);
        @(negedge clk);
        check_eq("par_ready", 32'(bus.read_ready), 32'hF);
        check_eq("par_d0", 32'(bus.read_data[0]), 32'h11);
        check_eq("par_d1", 32'(bus.read_data[1]), 32'h22);
        check_eq("par_d2", 32'(bus.read_data[2]), 32'h33);
        check_eq("par_d3", 32'(bus.read_data[3]), 32'h44);
        bus.read_valid = 4'b0000;
        @(negedge clk);
        check_eq("par_drop", 32'(bus.read_ready), 32'd0);

        // Same-address same-edge writes: lowest channel wins.
        bus.write_address[1] = 8'h10;
        bus.write_data[1]    = 16'hAAAA;
        bus.write_address[3] = 8'h10;
        bus.write_data[3]    = 16'hBBBB;
        bus.write_valid      = 4'b1010;
        repeat (3) @(negedge clk);
        check_eq("coll_ready", 32'(bus.write_ready), 32'hA);
        bus.write_valid = 4'b0000;
        @(negedge clk);
        rd(0, 8'h10, 16'hAAAA, "coll_rd");

        // Read and write valid together on channel 2: read first, write after an idle cycle.
        wr(2, 8'h20, 16'h000F, "mix_pre");
        bus.read_valid[2]    = 1'b1;
        bus.read_address[2]  = 8'h20;
        bus.write_valid[2]   = 1'b1;
        bus.write_address[2] = 8'h20;
        bus.write_data[2]    = 16'h00F0;
        repeat (3) @(negedge clk);
        check_eq("mix_rd_ready", 32'(bus.read_ready[2]), 32'd1);
        check_eq("mix_wr_idle", 32'(bus.write_ready[2]), 32'd0);
        check_eq("mix_rd_data", 32'(bus.read_data[2]), 32'h000F);
        bus.read_valid[2] = 1'b0;
        @(negedge clk);
        check_eq("mix_rd_drop", 32'(bus.read_ready[2]), 32'd0);
        check_eq("mix_wr_gap", 32'(bus.write_ready[2]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("mix_wr_early", 32'(bus.write_ready[2]), 32'd0);
        @(negedge clk);
        check_eq("mix_wr_ready", 32'(bus.write_ready[2]), 32'd1);
        bus.write_valid[2] = 1'b0;
        @(negedge clk);
        rd(0, 8'h20, 16'h00F0, "mix_rd2");

        // Asynchronous reset while channel 0 sits in READ_WAIT.
        bus.read_valid[0]   = 1'b1;
        bus.read_address[0] = 8'h05;
        @(negedge clk);
        check_eq("arst_pre_data", 32'(bus.read_data[0]), 32'h00F0);
        #1 reset = 1'b1;
        #1;
        check_eq("arst_ready", 32'(bus.read_ready[0]), 32'd0);
        check_eq("arst_data", 32'(bus.read_data[0]), 32'd0);
        bus.read_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd(0, 8'h05, 16'h1234, "arst_post");
        rd(1, 8'h10, 16'hAAAA, "arst_keep");

`ifdef DATA_MEM_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("stat_rd_rst", stat_read_count, 32'd0);
        check_eq("stat_wr_rst", stat_write_count, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        bus.read_address[0] = 8'h01;
        bus.read_address[1] = 8'h02;
        bus.read_valid      = 4'b0011;
        repeat (3) @(negedge clk);
        check_eq("stat_pair_ready", 32'(bus.read_ready), 32'h3);
        bus.read_valid = 4'b0000;
        @(negedge clk);
        check_eq("stat_rd_pair", stat_read_count, 32'd2);
        rd(2, 8'h03, 16'h0033, "stat_rd");
        wr(3, 8'h40, 16'h0001, "stat_wr1");
        wr(3, 8'h41, 16'h0002, "stat_wr2");
        check_eq("stat_rd_total", stat_read_count, 32'd3);
        check_eq("stat_wr_total", stat_write_count, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
